// File: rtl/hex_marquee_scroller.sv
// Scrolling message driver for a bank of active-low 7-segment digits.
// Prescaled auto-scroll, single-step, direction select and position load.
module hex_marquee_scroller #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_LEN = 6,
  parameter int TICK_DIV = 25000000,
  parameter logic [7*MSG_LEN-1:0] MSG = {
    7'h7F, 7'b0100100, 7'b1111010,
    7'b0001000, 7'b0000001, 7'h7F
  },
  localparam int POS_W = (MSG_LEN > 2) ? $clog2(MSG_LEN) : 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    dir,
  input  logic                    step_btn,
  input  logic                    load,
  input  logic [POS_W-1:0]        load_pos,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic [POS_W-1:0]        pos,
  output logic                    step
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [POS_W-1:0] LAST = POS_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]        cnt;
  logic                    step_btn_q;
  logic                    tick;
  logic                    btn_rise;
  logic                    adv;
  logic [POS_W-1:0]        adv_pos;
  logic [POS_W-1:0]        load_val;
  logic [POS_W-1:0]        idx;
  logic [7*NUM_DIGITS-1:0] frame;

  // Step requests and the candidate next positions.
  always_comb begin
    tick = en && (cnt == CNT_MAX);
    btn_rise = step_btn & ~step_btn_q;
    adv = tick | (btn_rise & ~en);
    if (dir)
      adv_pos = (pos == '0) ? LAST : pos - 1'b1;
    else
      adv_pos = (pos == LAST) ? '0 : pos + 1'b1;
    load_val = (int'(load_pos) >= MSG_LEN) ? '0 : load_pos;
  end

  // Digit k shows symbol (pos+k) mod MSG_LEN via a wrapping increment chain.
  always_comb begin
    frame = '0;
    idx = reset ? '0 : pos;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      for (int j = 0; j < MSG_LEN; j++) begin
        if (idx == POS_W'(j))
          frame[7*k +: 7] = MSG[7*j +: 7];
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  // Prescaler, button edge register, position and step pulse.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt <= '0;
      step_btn_q <= 1'b0;
      pos <= '0;
      step <= 1'b0;
    end else begin
      step_btn_q <= step_btn;
      if (load) begin
        pos <= load_val;
        cnt <= '0;
        step <= 1'b1;
      end else begin
        if (en)
          cnt <= tick ? '0 : cnt + 1'b1;
        if (adv) begin
          pos <= adv_pos;
          step <= 1'b1;
        end else begin
          step <= 1'b0;
        end
      end
    end
  end

  // Display register lags pos by one clock; shows pos 0 on reset.
  always_ff @(posedge CLOCK_50) begin
    hex_out <= frame;
  end

endmodule

// File: tb/tb_hex_marquee_scroller.sv
// Directed bench for hex_marquee_scroller with TICK_DIV=4.
// Immediate assertions at each check; summary line at the end.
module tb_hex_marquee_scroller;

  localparam int ND = 6;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          dir;
  logic          step_btn;
  logic          load;
  logic [PW-1:0] load_pos;
  logic [7*ND-1:0] hex_out;
  logic [PW-1:0] pos;
  logic          step;

  int tests = 0;
  int fails = 0;
  int nsteps;

  localparam logic [41:0] PAT0 = {
    7'h7F, 7'h24, 7'h7A, 7'h08, 7'h01, 7'h7F
  };

  hex_marquee_scroller #(
    .NUM_DIGITS(6),
    .MSG_LEN(6),
    .TICK_DIV(4)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .en(en),
    .dir(dir),
    .step_btn(step_btn),
    .load(load),
    .load_pos(load_pos),
    .hex_out(hex_out),
    .pos(pos),
    .step(step)
  );

  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] dig(input int k);
    return hex_out[7*k +: 7];
  endfunction

  initial begin
    reset = 1'b1;
    en = 1'b0;
    dir = 1'b0;
    step_btn = 1'b0;
    load = 1'b0;
    load_pos = '0;

    // 1: reset
    clk1();
    clk1();
    chk("rst_pos", 64'(pos), 64'd0);
    chk("rst_step", 64'(step), 64'd0);
    chk("rst_hex", 64'(hex_out), 64'(PAT0));
    reset = 1'b0;

    // 2: auto-scroll forward, step every 4th clock
    en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      clk1();
      if (i % 4 == 0) begin
        chk("fwd_step", 64'(step), 64'd1);
        chk("fwd_pos", 64'(pos), 64'((i / 4) % 6));
      end else begin
        chk("fwd_nostep", 64'(step), 64'd0);
      end
      if (i == 5) begin
        chk("p1_d0", 64'(dig(0)), 64'h01);
        chk("p1_d4", 64'(dig(4)), 64'h7F);
        chk("p1_d5", 64'(dig(5)), 64'h7F);
      end
    end

    // 3: reverse wraps 0 -> 5
    dir = 1'b1;
    repeat (3) clk1();
    chk("rev_wait", 64'(pos), 64'd0);
    clk1();
    chk("rev_pos", 64'(pos), 64'd5);
    chk("rev_step", 64'(step), 64'd1);
    clk1();
    chk("p5_d0", 64'(dig(0)), 64'h7F);
    chk("p5_d1", 64'(dig(1)), 64'h7F);
    chk("p5_d2", 64'(dig(2)), 64'h01);
    chk("p5_d3", 64'(dig(3)), 64'h08);

    // 4: paused single-step, held button gives one advance
    en = 1'b0;
    dir = 1'b0;
    step_btn = 1'b1;
    nsteps = 0;
    for (int i = 0; i < 10; i++) begin
      clk1();
      if (step) nsteps++;
    end
    chk("ss_once", 64'(nsteps), 64'd1);
    chk("ss_pos", 64'(pos), 64'd0);
    step_btn = 1'b0;
    clk1();
    en = 1'b1;
    step_btn = 1'b1;
    clk1();
    chk("ss_en_ign_pos", 64'(pos), 64'd0);
    chk("ss_en_ign_step", 64'(step), 64'd0);
    clk1();
    chk("ss_en_wait", 64'(pos), 64'd0);
    clk1();
    chk("ss_en_tick", 64'(pos), 64'd1);
    step_btn = 1'b0;

    // 5: load coincident with tick
    repeat (3) clk1();
    chk("ld_pre", 64'(pos), 64'd1);
    load = 1'b1;
    load_pos = 3'd3;
    clk1();
    load = 1'b0;
    chk("ld_pos", 64'(pos), 64'd3);
    chk("ld_step", 64'(step), 64'd1);
    clk1();
    chk("ld_single", 64'(step), 64'd0);
    repeat (2) clk1();
    chk("ld_cnt0", 64'(pos), 64'd3);
    clk1();
    chk("ld_next", 64'(pos), 64'd4);
    load = 1'b1;
    load_pos = 3'd7;
    clk1();
    chk("ld_oor", 64'(pos), 64'd0);
    load_pos = 3'd0;
    clk1();
    load = 1'b0;
    chk("ld_same_step", 64'(step), 64'd1);
    chk("ld_same_pos", 64'(pos), 64'd0);

    // 6: reset mid-count discards prescaler
    load = 1'b1;
    load_pos = 3'd4;
    clk1();
    load = 1'b0;
    repeat (2) clk1();
    chk("mr_pre", 64'(pos), 64'd4);
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    chk("mr_pos", 64'(pos), 64'd0);
    chk("mr_step", 64'(step), 64'd0);
    chk("mr_hex", 64'(hex_out), 64'(PAT0));
    nsteps = 0;
    repeat (3) begin
      clk1();
      if (step) nsteps++;
    end
    chk("mr_nostep", 64'(nsteps), 64'd0);
    clk1();
    chk("mr_step4", 64'(step), 64'd1);
    chk("mr_pos4", 64'(pos), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
